// File: rtl/exec_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes and FSM states.
package exec_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one step per advance.
// result is the value after this cycle's step, so it holds the final answer while lastStep is high.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               advance,
  input  logic               isDiv,
  input  logic [WIDTH-1:0]   magA,
  input  logic [WIDTH-1:0]   magB,
  output logic [2*WIDTH-1:0] result,
  output logic               lastStep
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    count;
  logic             divMode;
  logic [WIDTH-1:0] accHi, accLo, operand;
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic [WIDTH-1:0] nextHi, nextLo;

  // Divide: accHi is the partial remainder, accLo shifts dividend out and quotient in.
  // Multiply: accHi accumulates, accLo shifts the multiplier out and product bits in.
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    divShift = {accHi, accLo[WIDTH-1]};
    divDiff  = divShift - {1'b0, operand};
    if (divMode) begin
      nextHi = divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
      nextLo = {accLo[WIDTH-2:0], ~divDiff[WIDTH]};
    end else begin
      nextHi = mulSum[WIDTH:1];
      nextLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  assign result   = {nextHi, nextLo};
  assign lastStep = (count == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      divMode <= 1'b0;
      accHi   <= '0;
      accLo   <= '0;
      operand <= '0;
    end else if (start) begin
      count   <= CW'(WIDTH - 1);
      divMode <= isDiv;
      accHi   <= '0;
      accLo   <= isDiv ? magA : magB;
      operand <= isDiv ? magB : magA;
    end else if (advance) begin
      accHi <= nextHi;
      accLo <= nextLo;
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// HI/LO multiply/divide unit beside the execute ALU: FSM, sign handling, special cases,
// architectural HI/LO and flush. Stalls the pipeline while an iterative op runs.
module exec_muldiv
  import exec_muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  muldiv_state_t state, stateNext;

  logic               isMul, isDiv, isSigned, isIter, accept, startIter, lastStep;
  logic               signA, signB;
  logic [WIDTH-1:0]   magA, magB;
  logic [2*WIDTH-1:0] extA, extB, fastProd, rawResult, mulFix;
  logic [WIDTH-1:0]   hiReg, loReg, pendHi, pendLo, aSaved;
  logic               negRes, negRem, divZero, opIsDiv;
  logic [WIDTH-1:0]   quot, rem, corrHi, corrLo;

  assign isMul     = (op_i == MD_MULT) || (op_i == MD_MULTU);
  assign isDiv     = (op_i == MD_DIV) || (op_i == MD_DIVU);
  assign isSigned  = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign isIter    = isDiv || (isMul && !FAST_MUL);
  assign accept    = (state == IDLE) && valid_i && !flush_i;
  assign startIter = accept && isIter;

  assign signA = isSigned & a_i[WIDTH-1];
  assign signB = isSigned & b_i[WIDTH-1];
  assign magA  = signA ? -a_i : a_i;
  assign magB  = signB ? -b_i : b_i;
  assign extA  = isSigned ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
  assign extB  = isSigned ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
  assign fastProd = extA * extB;

  muldiv_iter_core #(.WIDTH(WIDTH)) uCore (
    .clk      (clk),
    .resetn   (resetn),
    .start    (startIter),
    .advance  (state == RUN),
    .isDiv    (isDiv),
    .magA     (magA),
    .magB     (magB),
    .result   (rawResult),
    .lastStep (lastStep)
  );

  // min_int / -1 needs no special path: magnitude quotient 2^(WIDTH-1) negates back to min_int.
  always_comb begin
    mulFix = negRes ? -rawResult : rawResult;
    quot   = rawResult[WIDTH-1:0];
    rem    = rawResult[2*WIDTH-1:WIDTH];
    corrHi = mulFix[2*WIDTH-1:WIDTH];
    corrLo = mulFix[WIDTH-1:0];
    if (opIsDiv) begin
      if (divZero) begin
        corrHi = aSaved;
        corrLo = '1;
      end else begin
        corrHi = negRem ? -rem : rem;
        corrLo = negRes ? -quot : quot;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (startIter) stateNext = RUN;
      RUN: begin
        if (flush_i)       stateNext = IDLE;
        else if (lastStep) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      opIsDiv <= 1'b0;
      aSaved  <= '0;
      pendHi  <= '0;
      pendLo  <= '0;
    end else begin
      if (startIter) begin
        negRes  <= signA ^ signB;
        negRem  <= signA;
        divZero <= isDiv && (b_i == '0);
        opIsDiv <= isDiv;
        aSaved  <= a_i;
      end
      if (state == RUN && lastStep) begin
        pendHi <= corrHi;
        pendLo <= corrLo;
      end
    end
  end

  // Architectural HI/LO: single-cycle writes from IDLE, iterative results commit from DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (accept) begin
      if (op_i == MD_MTHI)          hiReg <= a_i;
      else if (op_i == MD_MTLO)     loReg <= a_i;
      else if (isMul && FAST_MUL)   {hiReg, loReg} <= fastProd;
    end else if (state == DONE && !flush_i) begin
      hiReg <= pendHi;
      loReg <= pendLo;
    end
  end

  assign stall_o = startIter || (state == RUN);
  assign busy_o  = (state == RUN);
  assign done_o  = (state == DONE);
  assign hi_o    = (state == DONE) ? pendHi : hiReg;
  assign lo_o    = (state == DONE) ? pendLo : loReg;

endmodule

// File: tb/tb_exec_muldiv.sv
// Randomized self-checking bench for exec_muldiv: an iterative instance and a fast-multiply
// instance, checked against a plain-arithmetic HI/LO reference model.
module tb_exec_muldiv;
  import exec_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0, resetn = 1'b0, validSlow = 1'b0, validFast = 1'b0, flush = 1'b0;
  logic [2:0]   opIn = 3'd0;
  logic [W-1:0] aIn = '0, bIn = '0;
  logic         stallSlow, busySlow, doneSlow, stallFast, busyFast, doneFast;
  logic [W-1:0] hiSlow, loSlow, hiFast, loFast;
  logic [W-1:0] modelHi = '0, modelLo = '0;
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

  exec_muldiv #(.WIDTH(W), .FAST_MUL(1'b0)) dut (
    .clk(clk), .resetn(resetn), .valid_i(validSlow), .op_i(opIn), .a_i(aIn), .b_i(bIn),
    .flush_i(flush), .stall_o(stallSlow), .busy_o(busySlow), .done_o(doneSlow),
    .hi_o(hiSlow), .lo_o(loSlow)
  );

  exec_muldiv #(.WIDTH(W), .FAST_MUL(1'b1)) dutFast (
    .clk(clk), .resetn(resetn), .valid_i(validFast), .op_i(opIn), .a_i(aIn), .b_i(bIn),
    .flush_i(flush), .stall_o(stallFast), .busy_o(busyFast), .done_o(doneFast),
    .hi_o(hiFast), .lo_o(loFast)
  );

  // Reference result as {HI, LO} straight from the arithmetic rules.
  function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              qa, qb;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == MD_DIV) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
          qa = $signed(a);
          qb = $signed(b);
          q  = qa / qb;
          r  = qa % qb;
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issues one iterative op on the slow instance and watches it for a fixed window.
  // Cycle 0 is the accept cycle; RUN-cycle inputs are randomized to show they are ignored.
  task automatic driveIter(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int flushAt, input bit flushInDone,
                           output int stallCnt, output int doneCyc,
                           output logic [W-1:0] hiDone, output logic [W-1:0] loDone,
                           output logic busyAfter);
    stallCnt = 0; doneCyc = 0; hiDone = '0; loDone = '0; busyAfter = 1'b1;
    @(posedge clk); #1;
    validSlow = 1'b1; opIn = op; aIn = a; bIn = b;
    #1;
    if (stallSlow) stallCnt++;
    @(posedge clk); #1;
    validSlow = 1'b0;
    for (int c = 1; c <= W + 4; c++) begin
      flush = (c == flushAt);
      validSlow = (flushAt == 0) && (c <= W);
      opIn = 3'($urandom_range(0, 5));
      aIn = $urandom;
      bIn = $urandom;
      #1;
      if (stallSlow) stallCnt++;
      if (c == flushAt + 1) busyAfter = busySlow;
      if (doneSlow && doneCyc == 0) begin
        doneCyc = c;
        hiDone = hiSlow;
        loDone = loSlow;
        if (flushInDone) flush = 1'b1;
      end
      @(posedge clk); #1;
      flush = 1'b0;
      validSlow = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #2;
    checks++;
    if ({stallSlow, busySlow, doneSlow} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {stallSlow, busySlow, doneSlow});
    end
    checks++;
    if ({hiSlow, loSlow} !== 64'd0) begin
      errors++; $display("[TB] FAIL reset_hilo: got %h expected 0", {hiSlow, loSlow});
    end
    checks++;
    if ({stallFast, busyFast, doneFast, hiFast, loFast} !== 67'd0) begin
      errors++; $display("[TB] FAIL reset_fast: got %h expected 0", {stallFast, busyFast, doneFast, hiFast, loFast});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
  endtask

  task automatic test_multu_timing;
    int stallCnt, doneCyc;
    logic [W-1:0] hD, lD;
    logic busyA;
    driveIter(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, stallCnt, doneCyc, hD, lD, busyA);
    checks++;
    if (stallCnt !== 33) begin
      errors++; $display("[TB] FAIL multu_stall_cycles: got %0d expected 33", stallCnt);
    end
    checks++;
    if (doneCyc !== 33) begin
      errors++; $display("[TB] FAIL multu_done_cycle: got %0d expected 33", doneCyc);
    end
    checks++;
    if ({hD, lD} !== 64'h0000_0001_FFFF_FFFE) begin
      errors++; $display("[TB] FAIL multu_done_value: got %h expected 00000001fffffffe", {hD, lD});
    end
    {modelHi, modelLo} = 64'h0000_0001_FFFF_FFFE;
    checks++;
    if ({hiSlow, loSlow} !== {modelHi, modelLo}) begin
      errors++; $display("[TB] FAIL multu_commit: got %h expected %h", {hiSlow, loSlow}, {modelHi, modelLo});
    end
  endtask

  task automatic test_div_special;
    int stallCnt, doneCyc;
    logic [W-1:0] hD, lD;
    logic busyA;
    driveIter(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, stallCnt, doneCyc, hD, lD, busyA);
    checks++;
    if ({hiSlow, loSlow} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("[TB] FAIL div_neg7_by_2: got %h expected fffffffffffffffd", {hiSlow, loSlow});
    end
    driveIter(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, stallCnt, doneCyc, hD, lD, busyA);
    checks++;
    if ({hiSlow, loSlow} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("[TB] FAIL div_overflow: got %h expected 0000000080000000", {hiSlow, loSlow});
    end
    driveIter(MD_DIVU, 32'h1234_5678, 32'd0, 0, 1'b0, stallCnt, doneCyc, hD, lD, busyA);
    checks++;
    if ({hiSlow, loSlow} !== 64'h1234_5678_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL divu_by_zero: got %h expected 12345678ffffffff", {hiSlow, loSlow});
    end
    checks++;
    if (doneCyc !== 33) begin
      errors++; $display("[TB] FAIL divu_done_cycle: got %0d expected 33", doneCyc);
    end
    {modelHi, modelLo} = 64'h1234_5678_FFFF_FFFF;
  endtask

  task automatic test_random_iter;
    int stallCnt, doneCyc;
    logic [W-1:0] hD, lD, a, b;
    logic [2:0] op;
    logic [63:0] exp;
    logic busyA;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp = refModel(op, a, b);
      driveIter(op, a, b, 0, 1'b0, stallCnt, doneCyc, hD, lD, busyA);
      checks++;
      if ({stallCnt, doneCyc} !== {32'd33, 32'd33}) begin
        errors++; $display("[TB] FAIL rand_timing[%0d]: got stall=%0d done=%0d expected 33/33", i, stallCnt, doneCyc);
      end
      checks++;
      if ({hD, lD} !== exp) begin
        errors++; $display("[TB] FAIL rand_done[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, {hD, lD}, exp);
      end
      checks++;
      if ({hiSlow, loSlow} !== exp) begin
        errors++; $display("[TB] FAIL rand_commit[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, {hiSlow, loSlow}, exp);
      end
      {modelHi, modelLo} = exp;
    end
  endtask

  task automatic test_flush_run;
    int stallCnt, doneCyc;
    logic [W-1:0] hD, lD;
    logic busyA;
    driveIter(MD_DIVU, 32'd100, 32'd7, 10, 1'b0, stallCnt, doneCyc, hD, lD, busyA);
    checks++;
    if (busyA !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_run_idle: got busy=%b expected 0", busyA);
    end
    checks++;
    if (doneCyc !== 0 || stallCnt !== 11) begin
      errors++; $display("[TB] FAIL flush_run_done: got done=%0d stall=%0d expected 0/11", doneCyc, stallCnt);
    end
    checks++;
    if ({hiSlow, loSlow} !== {modelHi, modelLo}) begin
      errors++; $display("[TB] FAIL flush_run_hilo: got %h expected %h", {hiSlow, loSlow}, {modelHi, modelLo});
    end
  endtask

  task automatic test_flush_done;
    int stallCnt, doneCyc;
    logic [W-1:0] hD, lD;
    logic busyA;
    driveIter(MD_DIVU, 32'd100, 32'd7, 0, 1'b1, stallCnt, doneCyc, hD, lD, busyA);
    checks++;
    if (doneCyc !== 33 || {hD, lD} !== {32'd2, 32'd14}) begin
      errors++; $display("[TB] FAIL flush_done_shown: got cyc=%0d %h expected 33 %h", doneCyc, {hD, lD}, {32'd2, 32'd14});
    end
    checks++;
    if ({hiSlow, loSlow} !== {modelHi, modelLo}) begin
      errors++; $display("[TB] FAIL flush_done_commit: got %h expected %h", {hiSlow, loSlow}, {modelHi, modelLo});
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] oldHi;
    oldHi = modelHi;
    @(posedge clk); #1;
    validSlow = 1'b1; opIn = MD_MTHI; aIn = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({stallSlow, hiSlow} !== {1'b0, oldHi}) begin
      errors++; $display("[TB] FAIL mthi_cycle: got stall=%b hi=%h expected 0 %h", stallSlow, hiSlow, oldHi);
    end
    @(posedge clk); #1;
    opIn = MD_MTLO; aIn = 32'h1;
    #1;
    checks++;
    if ({stallSlow, hiSlow} !== {1'b0, 32'hDEAD_BEEF}) begin
      errors++; $display("[TB] FAIL mtlo_cycle: got stall=%b hi=%h expected 0 deadbeef", stallSlow, hiSlow);
    end
    @(posedge clk); #1;
    validSlow = 1'b0;
    {modelHi, modelLo} = {32'hDEAD_BEEF, 32'h1};
    checks++;
    if ({hiSlow, loSlow} !== {modelHi, modelLo}) begin
      errors++; $display("[TB] FAIL mt_result: got %h expected %h", {hiSlow, loSlow}, {modelHi, modelLo});
    end
  endtask

  task automatic test_flush_idle;
    @(posedge clk); #1;
    validSlow = 1'b1; validFast = 1'b1; flush = 1'b1; opIn = MD_MTLO; aIn = ~modelLo;
    @(posedge clk); #1;
    validSlow = 1'b0; validFast = 1'b0; flush = 1'b0;
    checks++;
    if ({hiSlow, loSlow} !== {modelHi, modelLo}) begin
      errors++; $display("[TB] FAIL flush_idle: got %h expected %h", {hiSlow, loSlow}, {modelHi, modelLo});
    end
  endtask

  task automatic test_fast_mul;
    logic [63:0] exp;
    @(posedge clk); #1;
    validFast = 1'b1; opIn = MD_MULT; aIn = 32'hFFFF_FFFD; bIn = 32'd5;
    #1;
    checks++;
    if ({stallFast, busyFast} !== 2'b00) begin
      errors++; $display("[TB] FAIL fast_stall: got %b expected 00", {stallFast, busyFast});
    end
    @(posedge clk); #1;
    validFast = 1'b0;
    checks++;
    if ({hiFast, loFast} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errors++; $display("[TB] FAIL fast_neg3x5: got %h expected fffffffffffffff1", {hiFast, loFast});
    end
    for (int i = 0; i < 6; i++) begin
      opIn = 3'($urandom_range(0, 1));
      aIn = $urandom;
      bIn = $urandom;
      exp = refModel(opIn, aIn, bIn);
      validFast = 1'b1;
      @(posedge clk); #1;
      validFast = 1'b0;
      checks++;
      if ({stallFast, hiFast, loFast} !== {1'b0, exp}) begin
        errors++; $display("[TB] FAIL fast_rand[%0d]: got stall=%b %h expected 0 %h", i, stallFast, {hiFast, loFast}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int stallCnt, doneCyc;
    logic [W-1:0] hD, lD, a, b;
    logic [63:0] exp;
    logic busyA;
    @(posedge clk); #1;
    validSlow = 1'b1; opIn = MD_MULT; aIn = $urandom; bIn = $urandom;
    @(posedge clk); #1;
    validSlow = 1'b0;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    checks++;
    if ({stallSlow, busySlow, doneSlow, hiSlow, loSlow} !== 67'd0) begin
      errors++; $display("[TB] FAIL async_reset_slow: got %h expected 0", {stallSlow, busySlow, doneSlow, hiSlow, loSlow});
    end
    checks++;
    if ({hiFast, loFast} !== 64'd0) begin
      errors++; $display("[TB] FAIL async_reset_fast: got %h expected 0", {hiFast, loFast});
    end
    @(negedge clk) resetn = 1'b1;
    a = $urandom;
    b = $urandom;
    exp = refModel(MD_MULT, a, b);
    driveIter(MD_MULT, a, b, 0, 1'b0, stallCnt, doneCyc, hD, lD, busyA);
    checks++;
    if ({stallCnt, doneCyc} !== {32'd33, 32'd33}) begin
      errors++; $display("[TB] FAIL post_reset_timing: got stall=%0d done=%0d expected 33/33", stallCnt, doneCyc);
    end
    checks++;
    if ({hiSlow, loSlow} !== exp) begin
      errors++; $display("[TB] FAIL post_reset_mult: got %h expected %h", {hiSlow, loSlow}, exp);
    end
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_div_special();
    test_random_iter();
    test_flush_run();
    test_flush_done();
    test_back_to_back();
    test_flush_idle();
    test_fast_mul();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
